// File: rtl/conv_window_gen.sv
// rtl/conv_window_gen.sv - 3x3 valid-region window generator over a raster pixel stream
// Optional stall counter output under CONV_WIN_PERF_EN.
module conv_window_gen #(
   parameter int DATA_WIDTH = 16,
   parameter int MAX_COLS   = 512,
   parameter int DIM_WIDTH  = 10
) (
   input  logic                    user_clk,
   input  logic                    user_rst_n,
   input  logic                    go,
   input  logic [DIM_WIDTH-1:0]    cols,
   input  logic [DIM_WIDTH-1:0]    rows,
   input  logic                    in_valid,
   input  logic [DATA_WIDTH-1:0]   in_data,
   output logic                    in_rd_en,
   output logic                    win_valid,
   input  logic                    win_ready,
   output logic [9*DATA_WIDTH-1:0] win_data,
   output logic                    done
`ifdef CONV_WIN_PERF_EN
   ,
   output logic [31:0]             stall_cycles
`endif
);

   localparam int AW = (MAX_COLS > 1) ? $clog2(MAX_COLS) : 1;
   localparam int CW = 2 * DIM_WIDTH;
   localparam logic [DIM_WIDTH-1:0] DIM_ONE   = DIM_WIDTH'(1);
   localparam logic [DIM_WIDTH-1:0] DIM_TWO   = DIM_WIDTH'(2);
   localparam logic [DIM_WIDTH-1:0] DIM_THREE = DIM_WIDTH'(3);
   localparam logic [DIM_WIDTH:0]   MAX_W     = (DIM_WIDTH+1)'(MAX_COLS);
   localparam logic [CW-1:0]        CNT_ONE   = CW'(1);

   typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;
   state_t state, state_nxt;

   logic [DIM_WIDTH-1:0]  cols_q, col, row;
   logic [CW-1:0]         pix_cnt, pix_total;
   logic                  degen;
   logic [DATA_WIDTH-1:0] lb0 [MAX_COLS];
   logic [DATA_WIDTH-1:0] lb1 [MAX_COLS];
   logic [DATA_WIDTH-1:0] win [9];
   logic [AW-1:0]         lb_addr;
   logic [DATA_WIDTH-1:0] lb0_rd, lb1_rd;
   logic                  accept, emit, last_pix, frame_empty;

   assign frame_empty = (rows == '0) || (cols == '0);
   assign accept      = in_valid && in_rd_en;
   assign lb_addr     = col[AW-1:0];
   assign lb0_rd      = lb0[lb_addr];
   assign lb1_rd      = lb1[lb_addr];
   assign last_pix    = (pix_cnt + CNT_ONE) == pix_total;
   // Row gating (y>=2) also hides line-buffer contents left over from earlier frames.
   assign emit        = accept && !degen && (row >= DIM_TWO) && (col >= DIM_TWO);

   always_ff @(posedge user_clk or negedge user_rst_n) begin
      if (!user_rst_n) state <= S_IDLE;
      else             state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         S_IDLE:  if (go) state_nxt = frame_empty ? S_DONE : S_RUN;
         S_RUN:   if (accept && last_pix) state_nxt = S_DRAIN;
         S_DRAIN: if (!win_valid || win_ready) state_nxt = S_DONE;
         S_DONE:  state_nxt = S_IDLE;
         default: state_nxt = S_IDLE;
      endcase
   end

   always_comb begin
      in_rd_en = (state == S_RUN) && (!win_valid || win_ready);
      done     = (state == S_DONE);
   end

   always_ff @(posedge user_clk or negedge user_rst_n) begin
      if (!user_rst_n) begin
         cols_q    <= '0;
         col       <= '0;
         row       <= '0;
         pix_cnt   <= '0;
         pix_total <= '0;
         degen     <= 1'b0;
         win_valid <= 1'b0;
         for (int i = 0; i < 9; i++) win[i] <= '0;
      end else begin
         if (state == S_IDLE && go) begin
            cols_q    <= cols;
            col       <= '0;
            row       <= '0;
            pix_cnt   <= '0;
            pix_total <= {{DIM_WIDTH{1'b0}}, rows} * {{DIM_WIDTH{1'b0}}, cols};
            degen     <= (cols < DIM_THREE) || (rows < DIM_THREE) || ({1'b0, cols} > MAX_W);
         end
         if (accept) begin
            pix_cnt <= pix_cnt + CNT_ONE;
            if (col == cols_q - DIM_ONE) begin
               col <= '0;
               row <= row + DIM_ONE;
            end else begin
               col <= col + DIM_ONE;
            end
            for (int r = 0; r < 3; r++) begin
               win[3*r]   <= win[3*r+1];
               win[3*r+1] <= win[3*r+2];
            end
            win[2] <= lb1_rd;
            win[5] <= lb0_rd;
            win[8] <= in_data;
         end
         if (emit)           win_valid <= 1'b1;
         else if (win_ready) win_valid <= 1'b0;
      end
   end

   always_ff @(posedge user_clk) begin
      if (accept && !degen) begin
         lb1[lb_addr] <= lb0_rd;
         lb0[lb_addr] <= in_data;
      end
   end

   always_comb begin
      win_data = '0;
      for (int i = 0; i < 9; i++) win_data[DATA_WIDTH*i +: DATA_WIDTH] = win[i];
   end

`ifdef CONV_WIN_PERF_EN
   always_ff @(posedge user_clk or negedge user_rst_n) begin
      if (!user_rst_n)
         stall_cycles <= '0;
      else if (state == S_IDLE && go)
         stall_cycles <= '0;
      else if ((state == S_RUN || state == S_DRAIN) && win_valid && !win_ready && (stall_cycles != '1))
         stall_cycles <= stall_cycles + 32'd1;
   end
`endif

endmodule

// File: tb/tb_conv_window_gen.sv
// tb/tb_conv_window_gen.sv - scoreboard bench for conv_window_gen
module tb_conv_window_gen;
   localparam int DW  = 16;
   localparam int MC  = 512;
   localparam int DIM = 10;
   localparam int WW  = 9 * DW;

   logic           clk = 1'b0;
   logic           rst_n = 1'b0;
   logic           go = 1'b0;
   logic [DIM-1:0] cols = '0;
   logic [DIM-1:0] rows = '0;
   logic           in_valid = 1'b0;
   logic [DW-1:0]  in_data = '0;
   logic           in_rd_en;
   logic           win_valid;
   logic           win_ready = 1'b0;
   logic [WW-1:0]  win_data;
   logic           done;
`ifdef CONV_WIN_PERF_EN
   logic [31:0]    stall_cycles;
`endif

   always #5 clk = ~clk;

   conv_window_gen #(.DATA_WIDTH(DW), .MAX_COLS(MC), .DIM_WIDTH(DIM)) dut (
      .user_clk   (clk),
      .user_rst_n (rst_n),
      .go         (go),
      .cols       (cols),
      .rows       (rows),
      .in_valid   (in_valid),
      .in_data    (in_data),
      .in_rd_en   (in_rd_en),
      .win_valid  (win_valid),
      .win_ready  (win_ready),
      .win_data   (win_data),
      .done       (done)
`ifdef CONV_WIN_PERF_EN
      ,
      .stall_cycles (stall_cycles)
`endif
   );

   int            errors = 0;
   int            checks = 0;
   logic [WW-1:0] exp_q [$];
   bit            sb_on = 1'b1;
   int            win_cnt = 0;
   int            done_cnt = 0;
   int            stall_obs = 0;
   int            rd_en_seen = 0;
   int            ready_mode = 0;
   logic          held = 1'b0;
   logic [WW-1:0] held_data = '0;
   logic [WW-1:0] first_win = '0;
   logic [WW-1:0] last_win = '0;

   task automatic check(input string name, input logic [WW-1:0] act, input logic [WW-1:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   function automatic logic [DW-1:0] pix(input int kind, input int y, input int x);
      case (kind)
         0:       return DW'(4 * y + x);
         1:       return DW'((y << 10) + x);
         2:       return DW'(256 + 3 * y + x);
         default: return DW'(40960 + 16 * y + x);
      endcase
   endfunction

   function automatic logic [WW-1:0] exp_win(input int kind, input int y, input int x);
      logic [WW-1:0] w = '0;
      for (int r = 0; r < 3; r++)
         for (int c = 0; c < 3; c++)
            w[DW*(3*r+c) +: DW] = pix(kind, y - 2 + r, x - 2 + c);
      return w;
   endfunction

   function automatic logic [WW-1:0] pack_arr(input int a [9]);
      logic [WW-1:0] w = '0;
      for (int i = 0; i < 9; i++) w[DW*i +: DW] = DW'(a[i]);
      return w;
   endfunction

   always @(posedge clk) begin
      #1;
      case (ready_mode)
         0:       win_ready = 1'b1;
         1:       win_ready = ~win_ready;
         default: win_ready = 1'b0;
      endcase
   end

   // Monitor: pops the scoreboard on every accepted window and checks hold stability.
   always @(negedge clk) begin
      if (done) done_cnt++;
      if (in_rd_en) rd_en_seen++;
      if (sb_on && rst_n) begin
         if (win_valid) begin
            if (held) check("hold_stable", win_data, held_data);
            if (win_ready) begin
               win_cnt++;
               if (win_cnt == 1) first_win = win_data;
               last_win = win_data;
               held = 1'b0;
               if (exp_q.size() == 0) begin
                  checks++;
                  errors++;
                  $display("FAIL unexpected_window: got %0h expected none", win_data);
               end else begin
                  check("window", win_data, exp_q.pop_front());
               end
            end else begin
               held      = 1'b1;
               held_data = win_data;
               stall_obs++;
            end
         end else if (held) begin
            checks++;
            errors++;
            $display("FAIL dropped_window: got valid=0 expected held %0h", held_data);
            held = 1'b0;
         end
      end
   end

   task automatic start_frame(input int r, input int c, input int kind, input bit push);
      @(posedge clk);
      #1;
      rows = DIM'(r);
      cols = DIM'(c);
      go   = 1'b1;
      win_cnt = 0;
      done_cnt = 0;
      stall_obs = 0;
      rd_en_seen = 0;
      if (push && r >= 3 && c >= 3 && c <= MC)
         for (int y = 2; y < r; y++)
            for (int x = 2; x < c; x++)
               exp_q.push_back(exp_win(kind, y, x));
      @(posedge clk);
      #1;
      go = 1'b0;
   endtask

   task automatic feed(input int kind, input int c, input int limit, input bit gaps, output int n);
      int  guard = 0;
      bit  xfer;
      n = 0;
      while (n < limit && guard < 20000) begin
         in_valid = gaps ? ($urandom_range(0, 2) != 0) : 1'b1;
         in_data  = pix(kind, n / c, n % c);
         @(negedge clk);
         xfer = in_valid && in_rd_en;
         @(posedge clk);
         #1;
         if (xfer) n++;
         guard++;
      end
      in_valid = 1'b0;
      if (n < limit) begin
         checks++;
         errors++;
         $display("FAIL feed_timeout: got %0d pixels expected %0d", n, limit);
      end
   endtask

   task automatic wait_done(output int lat);
      lat = 0;
      while (done_cnt == 0 && lat < 200) begin
         @(posedge clk);
         lat++;
      end
      repeat (3) @(posedge clk);
      #1;
      check("done_pulses", WW'(done_cnt), WW'(1));
   endtask

   int n;
   int lat;
   int hand_first [9] = '{0, 1, 2, 4, 5, 6, 8, 9, 10};
   int hand_last  [9] = '{5, 6, 7, 9, 10, 11, 13, 14, 15};
   int hand_3x3   [9] = '{256, 257, 258, 259, 260, 261, 262, 263, 264};

   initial begin
      repeat (3) @(posedge clk);
      #1;
      check("reset_in_rd_en", WW'(in_rd_en), WW'(0));
      check("reset_win_valid", WW'(win_valid), WW'(0));
      check("reset_win_data", win_data, WW'(0));
      check("reset_done", WW'(done), WW'(0));
      rst_n = 1'b1;

      ready_mode = 0;
      start_frame(4, 4, 0, 1);
      feed(0, 4, 16, 1'b0, n);
      wait_done(lat);
      check("f4x4_windows", WW'(win_cnt), WW'(4));
      check("f4x4_first", first_win, pack_arr(hand_first));
      check("f4x4_last", last_win, pack_arr(hand_last));
      check("f4x4_queue_empty", WW'(exp_q.size()), WW'(0));

      ready_mode = 1;
      start_frame(4, 4, 0, 1);
      feed(0, 4, 16, 1'b0, n);
      wait_done(lat);
      check("toggle_windows", WW'(win_cnt), WW'(4));
      check("toggle_queue_empty", WW'(exp_q.size()), WW'(0));
      check("toggle_stalls_seen", WW'(stall_obs > 0), WW'(1));
`ifdef CONV_WIN_PERF_EN
      check("stall_cycles", WW'(stall_cycles), WW'(stall_obs));
`endif

      ready_mode = 0;
      start_frame(3, MC, 1, 1);
      feed(1, MC, 3 * MC, 1'b1, n);
      wait_done(lat);
      check("wide_windows", WW'(win_cnt), WW'(MC - 2));
      check("wide_last", last_win, exp_win(1, 2, MC - 1));
      check("wide_queue_empty", WW'(exp_q.size()), WW'(0));

      start_frame(2, 5, 0, 1);
      feed(0, 5, 10, 1'b0, n);
      wait_done(lat);
      check("degen_pixels", WW'(n), WW'(10));
      check("degen_windows", WW'(win_cnt), WW'(0));

      start_frame(0, 7, 0, 1);
      wait_done(lat);
      check("rows0_no_rd_en", WW'(rd_en_seen), WW'(0));
      check("rows0_done_latency", WW'(lat <= 2), WW'(1));

      ready_mode = 2;
      sb_on = 1'b0;
      start_frame(6, 6, 3, 0);
      feed(3, 6, 15, 1'b0, n);
      repeat (2) @(posedge clk);
      #1;
      check("abort_pending_valid", WW'(win_valid), WW'(1));
      rst_n = 1'b0;
      #1;
      check("abort_win_valid", WW'(win_valid), WW'(0));
      check("abort_in_rd_en", WW'(in_rd_en), WW'(0));
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      ready_mode = 0;
      repeat (3) @(posedge clk);
      #1;
      check("abort_no_done", WW'(done_cnt), WW'(0));
      held = 1'b0;
      sb_on = 1'b1;
      start_frame(3, 3, 2, 1);
      feed(2, 3, 9, 1'b0, n);
      wait_done(lat);
      check("post_reset_windows", WW'(win_cnt), WW'(1));
      check("post_reset_window", first_win, pack_arr(hand_3x3));
      check("post_reset_queue_empty", WW'(exp_q.size()), WW'(0));

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1);
   end

endmodule
